// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The state encoding is fixed so other blocks and debug views can decode it.
package button_debouncer_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      IDLE_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing an asynchronous bit into clk.
// The output clears to 0 on a synchronous reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic sync0;
   logic sync1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
      end else begin
         sync0 <= d;
         sync1 <= sync0;
      end
   end

   assign q = sync1;

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button: synchronise, require a stable run of samples,
// then publish a clean level plus one-cycle press/release strobes.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             btn_s;
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             level_n;
   logic             press_n;
   logic             release_n;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE_LOW;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         btn_level     <= level_n;
         press_pulse   <= press_n;
         release_pulse <= release_n;
      end
   end

   // Any reversal during a check drops back to idle so the full run restarts.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      level_n   = btn_level;
      press_n   = 1'b0;
      release_n = 1'b0;
      unique case (state)
         IDLE_LOW: begin
            if (btn_s) begin
               state_n = CHECK_HIGH;
               cnt_n   = CNT_ONE;
            end
         end
         CHECK_HIGH: begin
            if (!btn_s) begin
               state_n = IDLE_LOW;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n = IDLE_HIGH;
               cnt_n   = '0;
               level_n = 1'b1;
               press_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!btn_s) begin
               state_n = CHECK_LOW;
               cnt_n   = CNT_ONE;
            end
         end
         CHECK_LOW: begin
            if (btn_s) begin
               state_n = IDLE_HIGH;
               cnt_n   = '0;
            end else if (cnt == CNT_LAST) begin
               state_n   = IDLE_LOW;
               cnt_n     = '0;
               level_n   = 1'b0;
               release_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: begin
            state_n = IDLE_LOW;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer with a run-length model:
// a level change is accepted once DEBOUNCE_CYCLES consecutive synced samples differ from it.
module tb_button_debouncer;

   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state
   logic inDelay[2];
   logic refLevel;
   logic refPress;
   logic refRelease;
   int   diffRun;

   int       pressSeen   = 0;
   int       releaseSeen = 0;
   logic [2:0] xCounter  = 3'd0;
   int       cycleNum    = 0;
   int       lastPressCycle = -1;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleNum, observed, expected);
      end
   endtask

   // Model of one clock edge: the input reaches the decision logic two samples late.
   task automatic modelEdge(input logic r, input logic b);
      logic synced;
      refPress   = 1'b0;
      refRelease = 1'b0;
      if (r) begin
         inDelay[0] = 1'b0;
         inDelay[1] = 1'b0;
         refLevel   = 1'b0;
         diffRun    = 0;
      end else begin
         synced     = inDelay[1];
         inDelay[1] = inDelay[0];
         inDelay[0] = b;
         if (synced != refLevel) begin
            diffRun++;
            if (diffRun == DEB) begin
               refLevel   = synced;
               refPress   = synced;
               refRelease = !synced;
               diffRun    = 0;
            end
         end else begin
            diffRun = 0;
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic b, input int n);
      for (int i = 0; i < n; i++) begin
         rst    = r;
         btn_in = b;
         @(posedge clk);
         modelEdge(r, b);
         cycleNum++;
         @(negedge clk);
         checkOutput("btn_level", int'(btn_level), int'(refLevel));
         checkOutput("press_pulse", int'(press_pulse), int'(refPress));
         checkOutput("release_pulse", int'(release_pulse), int'(refRelease));
         checkOutput("strobes_exclusive", int'(press_pulse & release_pulse), 0);
         if (press_pulse === 1'b1) begin
            pressSeen++;
            xCounter = xCounter + 3'd1;
            lastPressCycle = cycleNum;
         end
         if (release_pulse === 1'b1) releaseSeen++;
      end
   endtask

   initial begin
      int p0, r0, startCycle, holdLen;
      logic rb, rr;
      inDelay[0] = 1'b0;
      inDelay[1] = 1'b0;
      refLevel   = 1'b0;
      refPress   = 1'b0;
      refRelease = 1'b0;
      diffRun    = 0;
      rst    = 1'b1;
      btn_in = 1'b1;
      @(negedge clk);

      // Reset with the button held high: outputs stay low
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 4);

      // Clean press: press strobe exactly DEB+1 edges after the input is sampled
      p0 = pressSeen;
      startCycle = cycleNum;
      applyStimulus(1'b0, 1'b1, 20);
      checkOutput("press_latency", lastPressCycle - startCycle, DEB + 2);
      checkOutput("press_count_held", pressSeen - p0, 1);

      // Clean release
      r0 = releaseSeen;
      applyStimulus(1'b0, 1'b0, 12);
      checkOutput("release_count", releaseSeen - r0, 1);
      checkOutput("level_after_release", int'(btn_level), 0);

      // Bounce reject: too-short runs never produce a strobe
      p0 = pressSeen;
      r0 = releaseSeen;
      applyStimulus(1'b0, 1'b1, 2);
      applyStimulus(1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("bounce_press", pressSeen - p0, 0);
      checkOutput("bounce_release", releaseSeen - r0, 0);

      // Reset mid-check, then full re-detection with the button still held
      applyStimulus(1'b0, 1'b1, 4);
      applyStimulus(1'b1, 1'b1, 2);
      p0 = pressSeen;
      startCycle = cycleNum;
      applyStimulus(1'b0, 1'b1, 12);
      checkOutput("press_after_reset", pressSeen - p0, 1);
      checkOutput("latency_after_reset", lastPressCycle - startCycle, DEB + 2);
      applyStimulus(1'b0, 1'b0, 10);

      // Throughput: ten clean presses feed a 3-bit counter
      p0 = pressSeen;
      r0 = releaseSeen;
      xCounter = 3'd0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b1, 8);
         applyStimulus(1'b0, 1'b0, 8);
      end
      checkOutput("throughput_press", pressSeen - p0, 10);
      checkOutput("throughput_release", releaseSeen - r0, 10);
      checkOutput("counter_out", int'(xCounter), 2);

      // Random bouncing with occasional resets
      for (int k = 0; k < 150; k++) begin
         rb      = 1'($urandom_range(0, 1));
         rr      = ($urandom_range(0, 39) == 0);
         holdLen = $urandom_range(1, 2 * DEB + 1);
         applyStimulus(rr, rb, rr ? 1 : holdLen);
      end
      applyStimulus(1'b0, 1'b0, 10);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
